// File: rtl/biquad_cascade_engine.sv
// Time-multiplexed cascade of direct-form-I biquads sharing one signed MAC.
// One sample in, SECTIONS biquads evaluated serially, one saturated sample out.
`timescale 1ns/1ps
module biquad_cascade_engine #(
   parameter int N        = 24,
   parameter int F        = 15,
   parameter int SECTIONS = 2,
   parameter int AW       = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] x_in,
   output logic                out_valid,
   output logic signed [N-1:0] y_out,
   input  logic                coef_we,
   input  logic [AW-1:0]       coef_addr,
   input  logic signed [N-1:0] coef_wdata,
   output logic                coef_drop,
   input  logic                clear,
   output logic                sat
);
   localparam int NC   = 5 * SECTIONS;
   localparam int ACCW = 2 * N + 3;
   localparam int SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
   localparam logic [SW-1:0] LAST = SW'(SECTIONS - 1);

   typedef enum logic [1:0] {IDLE, MAC, UPD, OUTS} state_t;
   state_t state, state_nxt;

   logic signed [N-1:0]    coef [NC];
   logic signed [N-1:0]    x1 [SECTIONS];
   logic signed [N-1:0]    x2 [SECTIONS];
   logic signed [N-1:0]    y1 [SECTIONS];
   logic signed [N-1:0]    y2 [SECTIONS];
   logic signed [N-1:0]    x_cur;
   logic signed [ACCW-1:0] acc;
   logic [SW-1:0]          sec;
   logic [2:0]             tap;

   logic [AW-1:0]          cidx;
   logic signed [N-1:0]    opnd;
   logic signed [2*N-1:0]  prod;
   logic signed [ACCW-1:0] shifted;
   logic                   ovf_hi, ovf_lo;
   logic signed [N-1:0]    y_res;
   logic                   addr_ok;

   assign in_ready = (state == IDLE);
   assign addr_ok  = int'(coef_addr) < NC;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = MAC;
         MAC:  if (tap == 3'd4) state_nxt = UPD;
         UPD:  state_nxt = (sec == LAST) ? OUTS : MAC;
         OUTS: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   // Tap order matches coefficient order: b0 x, b1 x1, b2 x2, a1 y1, a2 y2.
   always_comb begin
      cidx = AW'(5 * int'(sec) + int'(tap));
      opnd = x_cur;
      case (tap)
         3'd1:    opnd = x1[sec];
         3'd2:    opnd = x2[sec];
         3'd3:    opnd = y1[sec];
         3'd4:    opnd = y2[sec];
         default: opnd = x_cur;
      endcase
   end

   assign prod    = coef[cidx] * opnd;
   assign shifted = acc >>> F;
   // Anything above bit N-1 that is not a copy of the sign bit is a clip.
   assign ovf_hi  = !shifted[ACCW-1] && (|shifted[ACCW-2:N-1]);
   assign ovf_lo  = shifted[ACCW-1] && !(&shifted[ACCW-2:N-1]);
   assign y_res   = ovf_hi ? {1'b0, {(N-1){1'b1}}} :
                    ovf_lo ? {1'b1, {(N-1){1'b0}}} : shifted[N-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NC; i++) coef[i] <= '0;
         for (int s = 0; s < SECTIONS; s++) begin
            x1[s] <= '0; x2[s] <= '0; y1[s] <= '0; y2[s] <= '0;
         end
         x_cur     <= '0;
         acc       <= '0;
         sec       <= '0;
         tap       <= '0;
         out_valid <= 1'b0;
         y_out     <= '0;
         coef_drop <= 1'b0;
         sat       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         coef_drop <= 1'b0;
         if (clear) begin
            for (int s = 0; s < SECTIONS; s++) begin
               x1[s] <= '0; x2[s] <= '0; y1[s] <= '0; y2[s] <= '0;
            end
            acc <= '0;
            sec <= '0;
            tap <= '0;
            sat <= 1'b0;
         end else begin
            if (coef_we) begin
               if (state == IDLE && addr_ok) coef[coef_addr] <= coef_wdata;
               else                          coef_drop       <= 1'b1;
            end
            case (state)
               IDLE: if (in_valid) begin
                  x_cur <= x_in;
                  sec   <= '0;
                  tap   <= '0;
               end
               MAC: begin
                  acc <= ((tap == 3'd0) ? '0 : acc) + ACCW'(prod);
                  tap <= tap + 3'd1;
               end
               UPD: begin
                  x2[sec] <= x1[sec];
                  x1[sec] <= x_cur;
                  y2[sec] <= y1[sec];
                  y1[sec] <= y_res;
                  x_cur   <= y_res;
                  tap     <= '0;
                  if (ovf_hi || ovf_lo) sat <= 1'b1;
                  if (sec != LAST) sec <= sec + SW'(1);
               end
               OUTS: begin
                  y_out     <= x_cur;
                  out_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_biquad_cascade_engine.sv
// Directed bench for biquad_cascade_engine (N=24, F=15, SECTIONS=2).
// Expected outputs are hand-computed fixed-point results.
`timescale 1ns/1ps
module tb_biquad_cascade_engine;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] x_in = '0;
   logic        out_valid;
   logic [23:0] y_out;
   logic        coef_we = 1'b0;
   logic [3:0]  coef_addr = '0;
   logic [23:0] coef_wdata = '0;
   logic        coef_drop;
   logic        clear = 1'b0;
   logic        sat;

   int n_chk = 0;
   int n_err = 0;

   biquad_cascade_engine #(.N(24), .F(15), .SECTIONS(2), .AW(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .out_valid(out_valid), .y_out(y_out), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_drop(coef_drop),
      .clear(clear), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [23:0] d);
      coef_addr = a; coef_wdata = d; coef_we = 1'b1;
      tick();
      coef_we = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic run(input logic [23:0] x, output logic [23:0] y, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      x_in = x; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      y = y_out;
   endtask

   // Starts a run, then aborts it at MAC tap 3 via clear (use_rst=0) or reset.
   task automatic abort_run(input bit use_rst, output int ov);
      x_in = 24'd500; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      if (use_rst) reset = 1'b1; else clear = 1'b1;
      tick();
      reset = 1'b0; clear = 1'b0;
      ov = 0;
      repeat (20) begin if (out_valid) ov++; tick(); end
   endtask

   initial begin
      logic [23:0] y;
      int lat, rdy_hi, drop_seen, ov;

      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_coef_drop", coef_drop, 0);
      chk("rst_sat", sat, 0);

      // passthrough
      wr(4'd0, 24'h008000);
      wr(4'd5, 24'h008000);
      run(24'd1000, y, lat);
      chk("pass_latency", lat, 13);
      chk("pass_y", y, 24'd1000);

      // FIR
      pulse_clear();
      wr(4'd0, 24'h004000);
      wr(4'd1, 24'h004000);
      run(24'd1000, y, lat); chk("fir_y0", y, 24'd500);
      run(24'd0, y, lat);    chk("fir_y1", y, 24'd500);
      run(24'd0, y, lat);    chk("fir_y2", y, 24'd0);
      chk("fir_sat", sat, 0);

      // feedback
      pulse_clear();
      wr(4'd0, 24'h008000);
      wr(4'd1, 24'h000000);
      wr(4'd3, 24'h004000);
      run(24'd1024, y, lat); chk("fb_y0", y, 24'd1024);
      run(24'd0, y, lat);    chk("fb_y1", y, 24'd512);
      run(24'd0, y, lat);    chk("fb_y2", y, 24'd256);
      run(24'd0, y, lat);    chk("fb_y3", y, 24'd128);

      // saturation
      pulse_clear();
      wr(4'd3, 24'h000000);
      wr(4'd0, 24'h018000);
      run(24'h7FFFFF, y, lat);
      chk("sat_pos_y", y, 24'h7FFFFF);
      chk("sat_pos_flag", sat, 1);
      run(24'h800000, y, lat);
      chk("sat_neg_y", y, 24'h800000);
      chk("sat_sticky", sat, 1);

      // busy rules
      pulse_clear();
      chk("clear_sat", sat, 0);
      wr(4'd0, 24'h008000);
      x_in = 24'd1000; in_valid = 1'b1;
      tick();
      x_in = 24'd2000;
      rdy_hi = 0; drop_seen = 0; lat = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_hi++;
         coef_we = (lat == 2); coef_addr = 4'd0; coef_wdata = 24'h001234;
         tick(); lat++;
         if (coef_drop) drop_seen++;
      end
      coef_we = 1'b0;
      chk("busy_ready_low", rdy_hi, 0);
      chk("busy_drop", drop_seen, 1);
      chk("busy_lat", lat, 13);
      chk("busy_y0", y_out, 24'd1000);
      tick();
      in_valid = 1'b0;
      chk("busy_reaccept", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      chk("busy_lat2", lat, 13);
      chk("busy_y1_bank", y_out, 24'd2000);
      wr(4'd10, 24'h000001);
      chk("idle_oor_drop", coef_drop, 1);
      wr(4'd4, 24'h000000);
      chk("idle_ok_nodrop", coef_drop, 0);

      // abort via clear
      pulse_clear();
      wr(4'd1, 24'h008000);
      run(24'd3000, y, lat);
      chk("abort_prerun", y, 24'd3000);
      abort_run(1'b0, ov);
      chk("abort_clr_noout", ov, 0);
      chk("abort_clr_ready", in_ready, 1);
      run(24'd1000, y, lat);
      chk("abort_clr_y", y, 24'd1000);

      // abort via reset: bank is zeroed, so reload it
      abort_run(1'b1, ov);
      chk("abort_rst_noout", ov, 0);
      chk("abort_rst_yout", y_out, 0);
      wr(4'd0, 24'h008000);
      wr(4'd1, 24'h008000);
      wr(4'd5, 24'h008000);
      run(24'd1000, y, lat);
      chk("abort_rst_y", y, 24'd1000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
